// File: rtl/up_datapath.sv
// Execution datapath of the 8-bit accumulator microprocessor: PC, IR, accumulator and
// registered-address RAM, driven by the control unit's per-cycle control word.
module up_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              IRload,
    input  logic              JMPmux,
    input  logic              PCload,
    input  logic              Meminst,
    input  logic              MemWr,
    input  logic              Aload,
    input  logic              Sub,
    input  logic [1:0]        Asel,
    input  logic [DATA_W-1:0] Input,
    input  logic              PROG_we,
    input  logic [ADDR_W-1:0] PROG_addr,
    input  logic [DATA_W-1:0] PROG_data,
    output logic [2:0]        IR_op,
    output logic              Aeq0,
    output logic              Apos,
    output logic [DATA_W-1:0] Aout,
    output logic [ADDR_W-1:0] PCout
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] opr;
    logic [ADDR_W-1:0] amux;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] a_src;
    logic [DATA_W-1:0] mem [DEPTH];

    assign opr   = ir[ADDR_W-1:0];
    assign amux  = Meminst ? opr : pc;
    assign rdata = mem[addr_q];
    assign alu   = Sub ? (a - rdata) : (a + rdata);

    always_comb begin
        a_src = '0;
        case (Asel)
            2'b00:   a_src = alu;
            2'b01:   a_src = Input;
            2'b10:   a_src = rdata;
            default: a_src = '0;
        endcase
    end

    // All register updates sample pre-edge values, so IRload+PCload and MemWr+Aload
    // in the same cycle each see the old IR / old A.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc     <= '0;
            ir     <= '0;
            a      <= '0;
            addr_q <= '0;
        end else begin
            addr_q <= amux;
            if (IRload) ir <= rdata;
            if (PCload) pc <= JMPmux ? opr : pc + 1'b1;
            if (Aload)  a  <= a_src;
        end
    end

    // Program loading stays live through reset and wins over a datapath store.
    always_ff @(posedge CLOCK) begin
        if (PROG_we)
            mem[PROG_addr] <= PROG_data;
        else if (MemWr && !RESET)
            mem[amux] <= a;
    end

    assign IR_op = ir[DATA_W-1:DATA_W-3];
    assign Aeq0  = (a == '0);
    assign Apos  = ~a[DATA_W-1];
    assign Aout  = a;
    assign PCout = pc;

endmodule
